// File: rtl/bitblade_bitserial_seq_pkg.sv
// Shared sizes, precision codes and FSM encoding for the BitBlade bit-serial sequencer.
package bitblade_bitserial_seq_pkg;

  localparam int N_DOT         = 32;
  localparam int BITS_PARALLEL = 2;
  localparam int PREC_MAX      = 8;
  localparam int BITS_SUM      = 10;
  localparam int BITS_ACC      = 24;

  localparam int VEC_W = N_DOT * PREC_MAX;
  localparam int SLC_W = N_DOT * BITS_PARALLEL;

  localparam logic [1:0] PREC_2B  = 2'b00;
  localparam logic [1:0] PREC_4B  = 2'b01;
  localparam logic [1:0] PREC_8B  = 2'b10;
  localparam logic [1:0] PREC_8BX = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Index of the last 2-bit plane for a precision code (plane count minus one).
  function automatic logic [1:0] prec_last_idx(input logic [1:0] code);
    case (code)
      PREC_2B: return 2'd0;
      PREC_4B: return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/bitblade_bitserial_seq_if.sv
// Vector-in / slice-out / result-out bundle of the bit-serial sequencer.
interface bitblade_bitserial_seq_if;
  import bitblade_bitserial_seq_pkg::*;

  logic                       i_Valid;
  logic                       o_Ready;
  logic [VEC_W-1:0]           i_ActVec;
  logic [VEC_W-1:0]           i_WeightVec;
  logic [1:0]                 i_PrecA;
  logic [1:0]                 i_PrecW;
  logic                       i_SignA;
  logic                       i_SignWt;
  logic [SLC_W-1:0]           o_Act;
  logic [SLC_W-1:0]           o_Weight;
  logic                       o_SignI;
  logic                       o_SignW;
  logic signed [BITS_SUM-1:0] i_SipSum;
  logic                       o_Valid;
  logic                       i_ResultReady;
  logic signed [BITS_ACC-1:0] o_Result;

  modport slave (
    input  i_Valid, i_ActVec, i_WeightVec, i_PrecA, i_PrecW, i_SignA, i_SignWt,
    input  i_SipSum, i_ResultReady,
    output o_Ready, o_Act, o_Weight, o_SignI, o_SignW, o_Valid, o_Result
  );

  modport master (
    output i_Valid, i_ActVec, i_WeightVec, i_PrecA, i_PrecW, i_SignA, i_SignWt,
    output i_SipSum, i_ResultReady,
    input  o_Ready, o_Act, o_Weight, o_SignI, o_SignW, o_Valid, o_Result
  );
endinterface

// File: rtl/bitblade_slice_mux.sv
// Picks 2-bit plane ia of every activation and plane iw of every weight.
module bitblade_slice_mux
  import bitblade_bitserial_seq_pkg::*;
(
  input  logic [VEC_W-1:0] act_vec,
  input  logic [VEC_W-1:0] wt_vec,
  input  logic [1:0]       ia,
  input  logic [1:0]       iw,
  output logic [SLC_W-1:0] act_slc,
  output logic [SLC_W-1:0] wt_slc
);

  // Per-element plane selection; element k lands at [2k +: 2].
  always_comb begin
    act_slc = '0;
    wt_slc  = '0;
    for (int k = 0; k < N_DOT; k++) begin
      act_slc[BITS_PARALLEL*k +: BITS_PARALLEL] =
        act_vec[PREC_MAX*k + BITS_PARALLEL*int'(ia) +: BITS_PARALLEL];
      wt_slc[BITS_PARALLEL*k +: BITS_PARALLEL] =
        wt_vec[PREC_MAX*k + BITS_PARALLEL*int'(iw) +: BITS_PARALLEL];
    end
  end

endmodule

// File: rtl/bitblade_bitserial_seq.sv
// BitBlade bit-serial sequencer: issues 2b plane pairs to the adder tree and
// shift-accumulates the returned slice sums into a full-precision dot product.
module bitblade_bitserial_seq
  import bitblade_bitserial_seq_pkg::*;
(
  input  logic                     i_CLK,
  input  logic                     i_RST,
  bitblade_bitserial_seq_if.slave  io
);

  state_t                     state;
  logic [VEC_W-1:0]           act_q;
  logic [VEC_W-1:0]           wt_q;
  logic [1:0]                 na_m1;
  logic [1:0]                 nw_m1;
  logic                       sign_a;
  logic                       sign_w;
  logic [1:0]                 ia;
  logic [1:0]                 iw;
  logic                       iss_act;
  logic                       vld_p1;
  logic                       last_p1;
  logic [3:0]                 shift_p1;
  logic signed [BITS_ACC-1:0] acc;
  logic signed [BITS_ACC-1:0] acc_nxt;
  logic [SLC_W-1:0]           act_slc;
  logic [SLC_W-1:0]           wt_slc;
  logic                       take;

  // Sign-extend a slice sum and weight it by its plane position.
  function automatic logic signed [BITS_ACC-1:0] slice_term(
    input logic signed [BITS_SUM-1:0] s,
    input logic [3:0]                 sh
  );
    logic signed [BITS_ACC-1:0] ext;
    ext = {{(BITS_ACC-BITS_SUM){s[BITS_SUM-1]}}, s};
    return ext <<< sh;
  endfunction

  bitblade_slice_mux u_slice_mux (
    .act_vec (act_q),
    .wt_vec  (wt_q),
    .ia      (ia),
    .iw      (iw),
    .act_slc (act_slc),
    .wt_slc  (wt_slc)
  );

  assign acc_nxt = acc + slice_term(io.i_SipSum, shift_p1);

  // A new pair is taken from IDLE, or from DONE in the same cycle the result drains.
  assign take = io.i_Valid &&
                ((state == ST_IDLE) || ((state == ST_DONE) && io.i_ResultReady));

  assign io.o_Ready = (state == ST_IDLE) || ((state == ST_DONE) && io.i_ResultReady);

  // Sequencer FSM: p0 = plane counter (ia,iw), p1 = registered slice on the tree,
  // accumulate when the p1 slice's sum comes back.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state       <= ST_IDLE;
      act_q       <= '0;
      wt_q        <= '0;
      na_m1       <= '0;
      nw_m1       <= '0;
      sign_a      <= 1'b0;
      sign_w      <= 1'b0;
      ia          <= '0;
      iw          <= '0;
      iss_act     <= 1'b0;
      vld_p1      <= 1'b0;
      last_p1     <= 1'b0;
      shift_p1    <= '0;
      acc         <= '0;
      io.o_Act    <= '0;
      io.o_Weight <= '0;
      io.o_SignI  <= 1'b0;
      io.o_SignW  <= 1'b0;
      io.o_Valid  <= 1'b0;
      io.o_Result <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          // p0 -> p1: present the current plane pair to the adder tree
          if (iss_act) begin
            io.o_Act    <= act_slc;
            io.o_Weight <= wt_slc;
            io.o_SignI  <= sign_a && (ia == na_m1);
            io.o_SignW  <= sign_w && (iw == nw_m1);
            vld_p1      <= 1'b1;
            last_p1     <= (ia == na_m1) && (iw == nw_m1);
            shift_p1    <= {({1'b0, ia} + {1'b0, iw}), 1'b0};
            if (ia == na_m1) begin
              ia <= '0;
              if (iw == nw_m1) iss_act <= 1'b0;
              else             iw      <= iw + 2'd1;
            end else begin
              ia <= ia + 2'd1;
            end
          end else begin
            io.o_Act    <= '0;
            io.o_Weight <= '0;
            io.o_SignI  <= 1'b0;
            io.o_SignW  <= 1'b0;
            vld_p1      <= 1'b0;
            last_p1     <= 1'b0;
          end
          // p1 -> accumulator: fold in the tree's sum for the presented slice
          if (vld_p1) begin
            acc <= acc_nxt;
            if (last_p1) begin
              io.o_Result <= acc_nxt;
              io.o_Valid  <= 1'b1;
              state       <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (io.i_ResultReady) begin
            io.o_Valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: ;
      endcase
      if (take) begin
        act_q    <= io.i_ActVec;
        wt_q     <= io.i_WeightVec;
        na_m1    <= prec_last_idx(io.i_PrecA);
        nw_m1    <= prec_last_idx(io.i_PrecW);
        sign_a   <= io.i_SignA;
        sign_w   <= io.i_SignWt;
        ia       <= '0;
        iw       <= '0;
        iss_act  <= 1'b1;
        vld_p1   <= 1'b0;
        last_p1  <= 1'b0;
        acc      <= '0;
        state    <= ST_RUN;
      end
    end
  end

endmodule

// File: tb/tb_bitblade_bitserial_seq.sv
// Directed bench for the BitBlade bit-serial sequencer with a behavioural 2b adder tree.
module tb_bitblade_bitserial_seq;
  import bitblade_bitserial_seq_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   si_hi;
  int   sw_hi;
  int   si_bad;
  int   sw_bad;

  bitblade_bitserial_seq_if io ();

  bitblade_bitserial_seq dut (
    .i_CLK (clk),
    .i_RST (rst),
    .io    (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream 2b multiply / adder tree model.
  always_comb begin
    int s;
    int ai;
    int wi;
    logic [1:0] a;
    logic [1:0] w;
    s = 0;
    for (int k = 0; k < N_DOT; k++) begin
      a  = io.o_Act[2*k +: 2];
      w  = io.o_Weight[2*k +: 2];
      ai = io.o_SignI ? int'($signed(a)) : int'(a);
      wi = io.o_SignW ? int'($signed(w)) : int'(w);
      s  = s + ai * wi;
    end
    io.i_SipSum = BITS_SUM'(s);
  end

  task automatic check_val(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_pair(input logic [7:0] av, input logic [7:0] wv,
                            input logic [1:0] pa, input logic [1:0] pw,
                            input logic sa, input logic sw);
    logic [VEC_W-1:0] va;
    logic [VEC_W-1:0] vw;
    for (int k = 0; k < N_DOT; k++) begin
      va[PREC_MAX*k +: PREC_MAX] = av;
      vw[PREC_MAX*k +: PREC_MAX] = wv;
    end
    io.i_ActVec    = va;
    io.i_WeightVec = vw;
    io.i_PrecA     = pa;
    io.i_PrecW     = pw;
    io.i_SignA     = sa;
    io.i_SignWt    = sw;
    io.i_Valid     = 1'b1;
    @(posedge clk); #1;
    io.i_Valid     = 1'b0;
    io.i_ActVec    = '0;
    io.i_WeightVec = '0;
  endtask

  task automatic sample_flags();
    if (io.o_SignI) si_hi++;
    if (io.o_SignW) sw_hi++;
    if (io.o_SignI != (io.o_Act[1:0] == 2'b10))    si_bad++;
    if (io.o_SignW != (io.o_Weight[1:0] == 2'b10)) sw_bad++;
  endtask

  task automatic wait_result(input string tag, input int exp_lat, input int exp_res);
    int  lat;
    logic got;
    lat = 0; got = 1'b0;
    si_hi = 0; sw_hi = 0; si_bad = 0; sw_bad = 0;
    while (!got && lat < 60) begin
      sample_flags();
      @(posedge clk); #1;
      lat++;
      if (io.o_Valid) got = 1'b1;
    end
    check_val({tag, "_latency"}, lat, exp_lat);
    check_val({tag, "_result"}, io.o_Result, exp_res);
  endtask

  task automatic consume(input string tag);
    io.i_ResultReady = 1'b1;
    @(posedge clk); #1;
    io.i_ResultReady = 1'b0;
    check_val({tag, "_valid_drop"}, io.o_Valid, 0);
    check_val({tag, "_ready_idle"}, io.o_Ready, 1);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    io.i_Valid = 1'b0; io.i_ActVec = '0; io.i_WeightVec = '0;
    io.i_PrecA = '0; io.i_PrecW = '0; io.i_SignA = 1'b0; io.i_SignWt = 1'b0;
    io.i_ResultReady = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ready",  io.o_Ready, 1);
    check_val("rst_valid",  io.o_Valid, 0);
    check_val("rst_result", io.o_Result, 0);
    check_val("rst_act",    (io.o_Act == '0) ? 1 : 0, 1);
    check_val("rst_signs",  {io.o_SignI, io.o_SignW}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 2b/2b unsigned, 3 x 3 x 32
    start_pair(8'd3, 8'd3, PREC_2B, PREC_2B, 1'b0, 1'b0);
    check_val("u2_ready_run", io.o_Ready, 0);
    wait_result("u2", 2, 288);
    consume("u2");

    // 8b/8b unsigned, 255 x 255 x 32
    start_pair(8'd255, 8'd255, PREC_8B, PREC_8BX, 1'b0, 1'b0);
    wait_result("u8", 17, 2080800);
    check_val("u8_signi_cnt", si_hi, 0);
    check_val("u8_signw_cnt", sw_hi, 0);
    check_val("u8_act_idle",  (io.o_Act == '0) ? 1 : 0, 1);
    consume("u8");

    // 8b/8b signed, -128 x -128 x 32
    start_pair(8'h80, 8'h80, PREC_8B, PREC_8B, 1'b1, 1'b1);
    wait_result("s8", 17, 524288);
    check_val("s8_signi_cnt", si_hi, 4);
    check_val("s8_signw_cnt", sw_hi, 4);
    check_val("s8_signi_pos", si_bad, 0);
    check_val("s8_signw_pos", sw_bad, 0);
    consume("s8");

    // 4b signed -3 activations, 8b unsigned 100 weights
    start_pair(8'hFD, 8'd100, PREC_4B, PREC_8B, 1'b1, 1'b0);
    wait_result("mix", 9, -9600);
    check_val("mix_signi_cnt", si_hi, 4);
    check_val("mix_signw_cnt", sw_hi, 0);
    consume("mix");

    // Backpressure, then back-to-back accept on the draining handshake
    start_pair(8'd1, 8'd2, PREC_2B, PREC_2B, 1'b0, 1'b0);
    wait_result("bp", 2, 64);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check_val("bp_hold_result", io.o_Result, 64);
      check_val("bp_hold_ready",  io.o_Ready, 0);
      check_val("bp_hold_valid",  io.o_Valid, 1);
    end
    io.i_ResultReady = 1'b1;
    #1;
    check_val("bp_ready_follow", io.o_Ready, 1);
    start_pair(8'd15, 8'd15, PREC_4B, PREC_4B, 1'b0, 1'b0);
    io.i_ResultReady = 1'b0;
    check_val("b2b_valid_drop", io.o_Valid, 0);
    check_val("b2b_in_run",     io.o_Ready, 0);
    wait_result("b2b", 5, 7200);
    consume("b2b");

    // Reset in the middle of an 8b/8b run
    start_pair(8'd255, 8'd255, PREC_8B, PREC_8B, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_val("mrst_act",    (io.o_Act == '0 && io.o_Weight == '0) ? 1 : 0, 1);
    check_val("mrst_valid",  io.o_Valid, 0);
    check_val("mrst_result", io.o_Result, 0);
    check_val("mrst_ready",  io.o_Ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    start_pair(8'h02, 8'd1, PREC_2B, PREC_2B, 1'b1, 1'b0);
    wait_result("post_rst", 2, -64);
    consume("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
